// File: rtl/bram_frame_writer_pkg.sv
// Shared types and constants for the frame-buffer capture path (package fw_pkg).
// Frame geometry defaults, state encoding and frame-tag width.
package fw_pkg;

    localparam int DEF_IN_W  = 640;
    localparam int DEF_IN_H  = 480;
    localparam int FRAME_PIX = DEF_IN_W * DEF_IN_H;
    localparam int DEF_AB    = $clog2(FRAME_PIX);
    localparam int TAG_W     = 4;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        WRITE    = 2'd1,
        COMMIT   = 2'd2
    } fw_state_e;

endpackage

// File: rtl/bram_frame_writer_if.sv
// Raster pixel stream into the frame writer: one pixel per valid cycle, no backpressure.
interface bram_frame_writer_if;
    import fw_pkg::*;

    logic             in_valid;
    logic             in_sof;
    logic             in_eol;
    logic [7:0]       in_data;
    logic [TAG_W-1:0] image_num_in;

    modport master (output in_valid, in_sof, in_eol, in_data, image_num_in);
    modport slave  (input  in_valid, in_sof, in_eol, in_data, image_num_in);
endinterface

// File: rtl/bram_frame_writer_xy_counter.sv
// Pixel position tracker: x/y coordinates plus a linear address kept in lock-step,
// so the BRAM address never needs a multiply.
module fw_xy_counter
    import fw_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int IN_H = DEF_IN_H,
    parameter int AB   = DEF_AB
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr,
    input  logic          sof_ld,
    input  logic          inc,
    output logic [AB-1:0] addr_r,
    output logic          last_x_s,
    output logic          last_y_s
);
    localparam int XW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int YW = (IN_H > 1) ? $clog2(IN_H) : 1;

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;

    assign last_x_s = (x_r == XW'(IN_W - 1));
    assign last_y_s = (y_r == YW'(IN_H - 1));

    // SOF pixel itself lands at address 0, so the load leaves the counter pointing at pixel 1
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            x_r    <= '0;
            y_r    <= '0;
            addr_r <= '0;
        end else if (sof_ld) begin
            x_r    <= XW'(1);
            y_r    <= '0;
            addr_r <= AB'(1);
        end else if (inc) begin
            if (last_x_s) begin
                x_r <= '0;
                y_r <= y_r + YW'(1);
            end else begin
                x_r <= x_r + XW'(1);
            end
            addr_r <= addr_r + AB'(1);
        end
    end
endmodule

// File: rtl/bram_frame_writer.sv
// Capture side of the ping-pong frame buffer: writes complete raster frames into BRAM Port-A.
// Optional FW_STATS_EN adds saturating committed-frame and dropped-frame counters.
module bram_frame_writer
    import fw_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int IN_H = DEF_IN_H,
    parameter int AB   = DEF_AB
) (
    input  logic             clk,
    input  logic             srst,
    bram_frame_writer_if.slave pix,
    output logic [AB-1:0]    addr_a,
    output logic [7:0]       din_a,
    output logic             we_a,
    output logic             wr_bank,
    output logic             swap,
    output logic [TAG_W-1:0] image_num_out,
    output logic             err_line,
    output logic             err_sof
`ifdef FW_STATS_EN
    ,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      drop_cnt
`endif
);
    fw_state_e        state_r, state_nx_s;
    logic [TAG_W-1:0] tag_r;
    logic [AB-1:0]    cnt_addr_s, addr_s;
    logic             last_x_s, last_y_s;
    logic             we_s, clr_s, sof_ld_s, inc_s, tag_ld_s, commit_s;
    logic             err_line_s, err_sof_s;

    fw_xy_counter #(.IN_W(IN_W), .IN_H(IN_H), .AB(AB)) u_xy (
        .clk      (clk),
        .srst     (srst),
        .clr      (clr_s),
        .sof_ld   (sof_ld_s),
        .inc      (inc_s),
        .addr_r   (cnt_addr_s),
        .last_x_s (last_x_s),
        .last_y_s (last_y_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r <= WAIT_SOF;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state, write strobe and error decode; SOF is checked before EOL so err_sof wins
    always_comb begin
        state_nx_s = state_r;
        we_s       = 1'b0;
        addr_s     = cnt_addr_s;
        clr_s      = 1'b0;
        sof_ld_s   = 1'b0;
        inc_s      = 1'b0;
        tag_ld_s   = 1'b0;
        commit_s   = 1'b0;
        err_line_s = 1'b0;
        err_sof_s  = 1'b0;
        case (state_r)
            WAIT_SOF, COMMIT: begin
                commit_s = (state_r == COMMIT);
                if (pix.in_valid && pix.in_sof) begin
                    we_s       = 1'b1;
                    addr_s     = '0;
                    sof_ld_s   = 1'b1;
                    tag_ld_s   = 1'b1;
                    state_nx_s = WRITE;
                end else begin
                    state_nx_s = WAIT_SOF;
                end
            end
            WRITE: begin
                if (!pix.in_valid) begin
                    state_nx_s = WRITE;
                end else if (pix.in_sof) begin
                    err_sof_s = 1'b1;
                    we_s      = 1'b1;
                    addr_s    = '0;
                    sof_ld_s  = 1'b1;
                    tag_ld_s  = 1'b1;
                end else if (pix.in_eol != last_x_s) begin
                    err_line_s = 1'b1;
                    clr_s      = 1'b1;
                    state_nx_s = WAIT_SOF;
                end else if (last_x_s && last_y_s) begin
                    we_s       = 1'b1;
                    state_nx_s = COMMIT;
                end else begin
                    we_s  = 1'b1;
                    inc_s = 1'b1;
                end
            end
            default: begin
                clr_s      = 1'b1;
                state_nx_s = WAIT_SOF;
            end
        endcase
    end

    // Registered Port-A outputs, bank flip and status pulses
    always_ff @(posedge clk) begin
        if (srst) begin
            addr_a        <= '0;
            din_a         <= 8'd0;
            we_a          <= 1'b0;
            wr_bank       <= 1'b0;
            swap          <= 1'b0;
            image_num_out <= '0;
            err_line      <= 1'b0;
            err_sof       <= 1'b0;
            tag_r         <= '0;
        end else begin
            we_a     <= we_s;
            swap     <= commit_s;
            wr_bank  <= wr_bank ^ commit_s;
            err_line <= err_line_s;
            err_sof  <= err_sof_s;
            if (we_s) begin
                addr_a <= addr_s;
                din_a  <= pix.in_data;
            end
            // a SOF in the commit cycle retags only after the old tag has been published
            if (commit_s) begin
                image_num_out <= tag_r;
            end
            if (tag_ld_s) begin
                tag_r <= pix.image_num_in;
            end
        end
    end

`ifdef FW_STATS_EN
    // Saturating frame statistics
    always_ff @(posedge clk) begin
        if (srst) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (commit_s && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if ((err_line_s || err_sof_s) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
